// File: rtl/mem_stage_dmem_if.sv
// mem_stage_dmem_if
//
// Memory stage of the pipeline. It issues loads and stores to a data memory
// whose latency varies, using a req/ready handshake. While an access is
// outstanding it stalls the upstream stages. It also drives the MEM/WB
// pipeline register.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   RegWriteM .. RDM         EX/MEM pipeline register outputs
//   DMemReq/WE/Addr/WData    request side of the data memory handshake
//   DMemRData, DMemReady     response side; data valid when ready is high
//   StallM                   freezes the F/D/E/M stages this cycle
//   *W, MemFaultW            registered MEM/WB outputs; the fault output
//                            pulses on a misaligned or timed-out access
//
// ResultSrc encoding: 00 = ALU result, 01 = memory read data, 10 = PC+4.

module mem_stage_dmem_if #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RDM,
    output logic        DMemReq,
    output logic        DMemWE,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        DMemReady,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RDW,
    output logic        MemFaultW
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Holding registers for the request in flight. These keep the memory
    // interface stable while the M inputs are ignored.
    logic        holdWe_q, holdWe_d;
    logic [31:0] holdAddr_q, holdAddr_d;
    logic [31:0] holdWData_q, holdWData_d;
    logic        holdRegWrite_q, holdRegWrite_d;
    logic [1:0]  holdResultSrc_q, holdResultSrc_d;
    logic [31:0] holdPc4_q, holdPc4_d;
    logic [4:0]  holdRd_q, holdRd_d;

    // MEM/WB register
    logic        regWriteW_q, regWriteW_d;
    logic [1:0]  resultSrcW_q, resultSrcW_d;
    logic [31:0] aluResultW_q, aluResultW_d;
    logic [31:0] readDataW_q, readDataW_d;
    logic [31:0] pc4W_q, pc4W_d;
    logic [4:0]  rdW_q, rdW_d;
    logic        faultW_q, faultW_d;

    logic accessNeeded;
    logic misaligned;
    logic reqRaw;
    logic stallRaw;

    assign accessNeeded = MemWriteM | (ResultSrcM == 2'b01);
    assign misaligned   = (ALUResultM[1:0] != 2'b00);

    // Reset forces the handshake and stall low without waiting for a clock
    // edge. An access in flight is therefore dropped at once.
    assign DMemReq = reqRaw & rst;
    assign StallM  = stallRaw & rst;

    assign RegWriteW  = regWriteW_q;
    assign ResultSrcW = resultSrcW_q;
    assign ALUResultW = aluResultW_q;
    assign ReadDataW  = readDataW_q;
    assign PCPlus4W   = pc4W_q;
    assign RDW        = rdW_q;
    assign MemFaultW  = faultW_q;

    // This block holds the next-state logic and all outputs. By default it
    // holds the state and loads a bubble into MEM/WB. Each branch then
    // overrides only the values it changes.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        holdWe_d        = holdWe_q;
        holdAddr_d      = holdAddr_q;
        holdWData_d     = holdWData_q;
        holdRegWrite_d  = holdRegWrite_q;
        holdResultSrc_d = holdResultSrc_q;
        holdPc4_d       = holdPc4_q;
        holdRd_d        = holdRd_q;
        regWriteW_d     = 1'b0;
        resultSrcW_d    = 2'b00;
        aluResultW_d    = 32'h0;
        readDataW_d     = 32'h0;
        pc4W_d          = 32'h0;
        rdW_d           = 5'h0;
        faultW_d        = 1'b0;
        reqRaw          = 1'b0;
        stallRaw        = 1'b0;
        DMemWE          = 1'b0;
        DMemAddr        = {ALUResultM[31:2], 2'b00};
        DMemWData       = WriteDataM;

        unique case (state_q)
            S_IDLE: begin
                if (accessNeeded && !misaligned) begin
                    reqRaw          = 1'b1;
                    DMemWE          = MemWriteM;
                    DMemAddr        = ALUResultM;
                    holdWe_d        = MemWriteM;
                    holdAddr_d      = ALUResultM;
                    holdWData_d     = WriteDataM;
                    holdRegWrite_d  = RegWriteM;
                    holdResultSrc_d = ResultSrcM;
                    holdPc4_d       = PCPlus4M;
                    holdRd_d        = RDM;
                    if (DMemReady) begin
                        regWriteW_d  = RegWriteM;
                        resultSrcW_d = ResultSrcM;
                        aluResultW_d = ALUResultM;
                        readDataW_d  = MemWriteM ? 32'h0 : DMemRData;
                        pc4W_d       = PCPlus4M;
                        rdW_d        = RDM;
                    end else begin
                        stallRaw = 1'b1;
                        state_d  = S_WAIT;
                        cnt_d    = 8'd1;
                    end
                end else begin
                    // A misaligned access still goes through MEM/WB,
                    // but it cannot write the register file.
                    regWriteW_d  = RegWriteM & ~(accessNeeded & misaligned);
                    resultSrcW_d = ResultSrcM;
                    aluResultW_d = ALUResultM;
                    pc4W_d       = PCPlus4M;
                    rdW_d        = RDM;
                    faultW_d     = accessNeeded & misaligned;
                end
            end

            S_WAIT: begin
                reqRaw    = 1'b1;
                DMemWE    = holdWe_q;
                DMemAddr  = holdAddr_q;
                DMemWData = holdWData_q;
                if (DMemReady || (cnt_q == LastWait)) begin
                    regWriteW_d  = holdRegWrite_q & DMemReady;
                    resultSrcW_d = holdResultSrc_q;
                    aluResultW_d = holdAddr_q;
                    readDataW_d  = (DMemReady && !holdWe_q) ? DMemRData : 32'h0;
                    pc4W_d       = holdPc4_q;
                    rdW_d        = holdRd_q;
                    faultW_d     = ~DMemReady;
                    state_d      = S_IDLE;
                    cnt_d        = 8'd0;
                end else begin
                    stallRaw = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // This block holds the state, the holding registers and the MEM/WB
    // register. Reset clears all of them, so an abandoned access leaves no
    // trace in writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            holdWe_q        <= 1'b0;
            holdAddr_q      <= 32'h0;
            holdWData_q     <= 32'h0;
            holdRegWrite_q  <= 1'b0;
            holdResultSrc_q <= 2'b00;
            holdPc4_q       <= 32'h0;
            holdRd_q        <= 5'h0;
            regWriteW_q     <= 1'b0;
            resultSrcW_q    <= 2'b00;
            aluResultW_q    <= 32'h0;
            readDataW_q     <= 32'h0;
            pc4W_q          <= 32'h0;
            rdW_q           <= 5'h0;
            faultW_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            holdWe_q        <= holdWe_d;
            holdAddr_q      <= holdAddr_d;
            holdWData_q     <= holdWData_d;
            holdRegWrite_q  <= holdRegWrite_d;
            holdResultSrc_q <= holdResultSrc_d;
            holdPc4_q       <= holdPc4_d;
            holdRd_q        <= holdRd_d;
            regWriteW_q     <= regWriteW_d;
            resultSrcW_q    <= resultSrcW_d;
            aluResultW_q    <= aluResultW_d;
            readDataW_q     <= readDataW_d;
            pc4W_q          <= pc4W_d;
            rdW_q           <= rdW_d;
            faultW_q        <= faultW_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem_if.sv
// Testbench for mem_stage_dmem_if.
//
// Each instruction is described at the transaction level. The description
// gives its fields and the number of wait cycles the memory inserts before
// it signals ready. The bench derives the expected handshake, stall pattern
// and MEM/WB contents from those values.

module tb_mem_stage_dmem_if;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RDM;
    logic        DMemReq;
    logic        DMemWE;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        DMemReady;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RDW;
    logic        MemFaultW;

    int nAsserts = 0;
    int nFail    = 0;

    mem_stage_dmem_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RDM        (RDM),
        .DMemReq    (DMemReq),
        .DMemWE     (DMemWE),
        .DMemAddr   (DMemAddr),
        .DMemWData  (DMemWData),
        .DMemRData  (DMemRData),
        .DMemReady  (DMemReady),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RDW        (RDW),
        .MemFaultW  (MemFaultW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through this task, which does the counting.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkW(input string tag, input logic rw, input logic [1:0] src,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pc4, input logic [4:0] rd,
                          input logic fault);
        checkOutput({tag, ".RegWriteW"},  32'(RegWriteW),  32'(rw));
        checkOutput({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(src));
        checkOutput({tag, ".ALUResultW"}, ALUResultW,      alu);
        checkOutput({tag, ".ReadDataW"},  ReadDataW,       rdata);
        checkOutput({tag, ".PCPlus4W"},   PCPlus4W,        pc4);
        checkOutput({tag, ".RDW"},        32'(RDW),        32'(rd));
        checkOutput({tag, ".MemFaultW"},  32'(MemFaultW),  32'(fault));
    endtask

    // The task presents one instruction and plays the memory side. The
    // memory answers after 'lat' wait cycles, where NEVER means no answer.
    // On entry and on exit the time is 1 unit after a rising edge.
    task automatic applyStimulus(input string tag, input logic rw, input logic we,
                                 input logic [1:0] src, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [31:0] pc4,
                                 input logic [4:0] rd, input int lat,
                                 input logic [31:0] rdata);
        logic access, mis, aligned, finalCycle, timedOut;
        int   k;
        access  = we || (src == 2'b01);
        mis     = (alu[1:0] != 2'b00);
        aligned = access && !mis;
        k = 0;
        finalCycle = 1'b0;
        while (!finalCycle) begin
            if (k == 0) begin
                RegWriteM = rw; MemWriteM = we; ResultSrcM = src;
                ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RDM = rd;
            end else begin
                // The M inputs must be ignored while waiting.
                RegWriteM  = 1'($urandom);
                MemWriteM  = 1'($urandom);
                ResultSrcM = 2'($urandom);
                ALUResultM = $urandom;
                WriteDataM = $urandom;
                PCPlus4M   = $urandom;
                RDM        = 5'($urandom);
            end
            if (aligned) begin
                DMemReady = (k == lat);
                DMemRData = (k == lat) ? rdata : $urandom;
            end else begin
                DMemReady = 1'($urandom);
                DMemRData = $urandom;
            end
            @(negedge clk);
            checkOutput({tag, ".DMemReq"}, 32'(DMemReq), 32'(aligned));
            checkOutput({tag, ".StallM"}, 32'(StallM),
                        32'(aligned && (k != lat) && (k != TIMEOUT - 1)));
            if (aligned) begin
                checkOutput({tag, ".DMemAddr"},  DMemAddr,      alu);
                checkOutput({tag, ".DMemWE"},    32'(DMemWE),   32'(we));
                checkOutput({tag, ".DMemWData"}, DMemWData,     wd);
            end
            finalCycle = !aligned || (k == lat) || (k == TIMEOUT - 1);
            timedOut   = aligned && (k != lat);
            @(posedge clk);
            #1;
            if (finalCycle)
                checkW(tag, rw && !(access && mis) && !timedOut, src, alu,
                       (aligned && !timedOut && !we) ? rdata : 32'h0,
                       pc4, rd, (access && mis) || timedOut);
            else
                checkW({tag, ".bubble"}, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
            k++;
        end
    endtask

    initial begin
        rst = 1'b0;
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01;
        ALUResultM = 32'h40; WriteDataM = 32'h0; PCPlus4M = 32'h4; RDM = 5'd3;
        DMemReady = 1'b1; DMemRData = 32'h1111_2222;

        // During reset the outputs are quiet even though a load is presented.
        #2;
        checkOutput("reset.DMemReq", 32'(DMemReq), 32'h0);
        checkOutput("reset.StallM",  32'(StallM),  32'h0);
        @(posedge clk);
        #1;
        checkW("reset", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        rst = 1'b1;

        $display("[TB] directed cases");
        applyStimulus("alu",      1'b1, 1'b0, 2'b00, 32'h1234, 32'h0,
                      32'h1000, 5'd5, 0, 32'h0);
        applyStimulus("ldZero",   1'b1, 1'b0, 2'b01, 32'h100, 32'h0,
                      32'h1004, 5'd6, 0, 32'hDEADBEEF);
        applyStimulus("ldWait3",  1'b1, 1'b0, 2'b01, 32'h200, 32'h0,
                      32'h1008, 5'd7, 3, 32'hCAFE0123);
        applyStimulus("stTimeout", 1'b0, 1'b1, 2'b00, 32'h8, 32'hA5A5A5A5,
                      32'h100C, 5'd0, NEVER, 32'h0);
        applyStimulus("ldMisalign", 1'b1, 1'b0, 2'b01, 32'h102, 32'h0,
                      32'h1010, 5'd9, 0, 32'h0);
        applyStimulus("ldLast",   1'b1, 1'b0, 2'b01, 32'h2C0, 32'h0,
                      32'h1014, 5'd10, TIMEOUT - 1, 32'h7777_8888);
        applyStimulus("jal",      1'b1, 1'b0, 2'b10, 32'h3, 32'h0,
                      32'h1018, 5'd1, 0, 32'h0);

        $display("[TB] random cases");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int lat;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
            applyStimulus("rand", 1'($urandom), 1'($urandom), 2'($urandom), a,
                          $urandom, $urandom, 5'($urandom), lat, $urandom);
        end

        $display("[TB] reset during wait");
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01;
        ALUResultM = 32'h300; WriteDataM = 32'h0; PCPlus4M = 32'h2000; RDM = 5'd12;
        DMemReady = 1'b0; DMemRData = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstWait.preReq", 32'(DMemReq), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("rstWait.DMemReq", 32'(DMemReq), 32'h0);
        checkOutput("rstWait.StallM",  32'(StallM),  32'h0);
        checkW("rstWait", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus("afterRst", 1'b1, 1'b0, 2'b00, 32'h5678, 32'h0,
                      32'h2004, 5'd13, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
